shifter_arbiter: RTL and testbench
==================================

// Module: shifter_arbiter
// PURPOSE
//  Shares one combinational 4-bit barrel shifter (Barrel_Shifter) between two requesters.
//  Arbitration is round-robin. Each port uses a valid/ready handshake.
//  The shifted result is registered into a one-entry output slot and tagged with the
//  requester ID. The consumer drains the slot with its own valid/ready handshake.
//  Per-requester saturating grant counters are provided for debug and fairness checks.
// PARAMETERS
//  CNT_W   8   width of each saturating grant counter
// PORTS
//  clk        in   1      rising-edge clock, single domain
//  rst        in   1      asynchronous, active-high reset
//  req_valid  in   2      request valid, one bit per requester (bit i = requester i)
//  req_a      in   8      operands; [4i+3:4i] = A of requester i
//  req_k      in   4      shift amounts; [2i+1:2i] = K of requester i
//  req_op     in   6      ops; [3i+2:3i] = {shift,left,arithmetic} of requester i
//  req_ready  out  2      request accepted this cycle when valid & ready
//  res_valid  out  1      output slot holds a result
//  res_data   out  4      shifted result
//  res_id     out  1      requester that issued res_data
//  res_ready  in   1      consumer accepts the result when res_valid & res_ready
//  grant_cnt0 out  CNT_W  saturating count of accepted requests from requester 0
//  grant_cnt1 out  CNT_W  saturating count of accepted requests from requester 1
// BEHAVIOUR
//  Reset values (asynchronous, all zero):
//   - state=EMPTY, res_valid=0, res_data=0, res_id=0
//   - rr_ptr=0 (requester 0 has priority first), grant_cnt0=grant_cnt1=0
//  States:
//   - EMPTY: slot free.
//   - FULL: slot holds an unconsumed result.
//  slot_free = (state==EMPTY) | res_ready   (pass-through drain allowed).
//  Grant is combinational:
//   - Only one valid requester: it wins.
//   - Both valid: requester rr_ptr wins.
//   - req_ready[i] = slot_free & grant[i]. At most one bit of req_ready is high; none if no valid.
//  Opcode {shift,left,arithmetic} follows the shifter encoding:
//   - 00x rotate right; 01x rotate left
//   - 100 logical right; 101 arithmetic right (sign = A[3])
//   - 110 and 111 logical left
//  On accept in cycle N, at the next edge:
//   - res_data <= shifter(A,K,op) of the winner; res_id <= winner
//   - state=FULL, so res_valid=1 in cycle N+1. Latency is exactly 1 cycle.
//   - rr_ptr <= ~winner
//   - grant_cnt[winner] increments and saturates at 2^CNT_W-1 (no wrap).
//  Simultaneous drain and accept in the same cycle:
//   - Slot is reloaded and stays FULL. Throughput is 1 result/cycle.
//  Drain with no accept: FULL -> EMPTY, res_valid=0. res_data holds its last value.
//  FULL & !res_ready:
//   - req_ready=0; res_data/res_id stable; rr_ptr and counters unchanged.
//   - Requesters must hold valid and payload stable until ready.
//  Requester drops valid while not granted: legal; nothing is recorded.
//  Reset asserted mid-operation:
//   - Pending result is discarded immediately (asynchronous).
//   - No handshake completes on the edge where rst is high.
//  Datapath width is fixed at 4 bits. K=0 passes A unchanged for every op.
// TESTING
//  1. Reset, then req0: A=1001 K=1 op=000 -> one cycle later res_valid=1, res_data=1100, res_id=0, grant_cnt0=1.
//  2. Both valid at once, res_ready=1 held:
//     - req0: A=1011 K=3 op=100; req1: A=1000 K=2 op=101
//     - Grants alternate 0,1,0,1. Results alternate 0001 / 1110 with ids 0,1,0,1.
//     - One result per cycle.
//  3. res_ready=0 with result pending -> req_ready=00; res_data/res_id stable 5 cycles.
//     Raising res_ready drains and accepts in the same cycle.
//  4. req1 only: A=0111 K=1 op=110 -> 1110; A=1001 K=1 op=010 -> 0011; K=0 any op -> A unchanged.
//  5. CNT_W=2: five accepted req0 transactions -> grant_cnt0 saturates at 3. grant_cnt1 stays 0.
//  6. Assert rst between accept and drain -> res_valid=0 and counters=0 immediately;
//     first grant after release goes to requester 0.

Source files
------------

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one 4-bit barrel shifter between two valid/ready requesters.
// Results land in a one-entry tagged output slot; per-requester saturating grant counters.
module shifter_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [7:0]       req_a,
  input  logic [3:0]       req_k,
  input  logic [5:0]       req_op,
  output logic [1:0]       req_ready,
  output logic             res_valid,
  output logic [3:0]       res_data,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             rr_ptr_r;
  logic [3:0]       res_data_r;
  logic             res_id_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  logic             slot_free_s;
  logic [1:0]       grant_s;
  logic [1:0]       ready_s;
  logic             accept_s;
  logic             winner_s;
  logic [3:0]       sel_a_s;
  logic [1:0]       sel_k_s;
  logic [2:0]       sel_op_s;
  logic [3:0]       shift_s;

  // op = {shift, left, arithmetic}; rotations wrap, shifts fill with zero or sign
  function automatic logic [3:0] barrel_shift(input logic [3:0] a,
                                              input logic [1:0] k,
                                              input logic [2:0] op);
    logic [2:0] inv_k;
    logic [3:0] res;
    inv_k = 3'd4 - {1'b0, k};
    case (op)
      3'b000, 3'b001: res = (a >> k) | (a << inv_k);
      3'b010, 3'b011: res = (a << k) | (a >> inv_k);
      3'b100:         res = a >> k;
      3'b101:         res = 4'($signed(a) >>> k);
      3'b110, 3'b111: res = a << k;
      default:        res = a;
    endcase
    return res;
  endfunction

  // Combinational grant: lone requester wins, ties go to rr_ptr; nothing handshakes during reset
  always_comb begin
    grant_s     = 2'b00;
    ready_s     = 2'b00;
    slot_free_s = (state_r == EMPTY) | res_ready;
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = rr_ptr_r ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
    if (rst) begin
      ready_s = 2'b00;
    end else if (slot_free_s) begin
      ready_s = grant_s;
    end else begin
      ready_s = 2'b00;
    end
  end

  assign accept_s = |ready_s;
  assign winner_s = ready_s[1];

  // Operand mux for the winning requester feeding the shared shifter
  always_comb begin
    sel_a_s  = req_a[3:0];
    sel_k_s  = req_k[1:0];
    sel_op_s = req_op[2:0];
    if (winner_s) begin
      sel_a_s  = req_a[7:4];
      sel_k_s  = req_k[3:2];
      sel_op_s = req_op[5:3];
    end else begin
      sel_a_s  = req_a[3:0];
      sel_k_s  = req_k[1:0];
      sel_op_s = req_op[2:0];
    end
    shift_s = barrel_shift(sel_a_s, sel_k_s, sel_op_s);
  end

  // Slot next-state: a reload keeps it FULL even while draining
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else if (res_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result payload, tag and round-robin pointer update on accept only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_r <= 4'b0000;
      res_id_r   <= 1'b0;
      rr_ptr_r   <= 1'b0;
    end else if (accept_s) begin
      res_data_r <= shift_s;
      res_id_r   <= winner_s;
      rr_ptr_r   <= ~winner_s;
    end
  end

  // Saturating grant counters; they stick at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (accept_s) begin
      if (!winner_s && (cnt0_r != CNT_MAX)) begin
        cnt0_r <= cnt0_r + CNT_ONE;
      end
      if (winner_s && (cnt1_r != CNT_MAX)) begin
        cnt1_r <= cnt1_r + CNT_ONE;
      end
    end
  end

  assign req_ready  = ready_s;
  assign res_valid  = (state_r == FULL);
  assign res_data   = res_data_r;
  assign res_id     = res_id_r;
  assign grant_cnt0 = cnt0_r;
  assign grant_cnt1 = cnt1_r;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: directed scenarios plus randomized traffic
// against an arithmetic reference model of the arbiter, slot and counters.
module tb_shifter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_a;
  logic [3:0] req_k;
  logic [5:0] req_op;
  logic       res_ready;

  logic [1:0] req_ready, req_ready_s;
  logic       res_valid, res_valid_s;
  logic [3:0] res_data, res_data_s;
  logic       res_id, res_id_s;
  logic [7:0] grant_cnt0, grant_cnt1;
  logic [1:0] sat_cnt0, sat_cnt1;

  int cmp_cnt = 0;
  int err_cnt = 0;

  int m_full, m_data, m_id, m_rr, m_c0, m_c1, m_s0, m_s1;
  logic [1:0] last_acc;

  shifter_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_k(req_k),
    .req_op(req_op), .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  shifter_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_k(req_k),
    .req_op(req_op), .req_ready(req_ready_s), .res_valid(res_valid_s), .res_data(res_data_s),
    .res_id(res_id_s), .res_ready(res_ready), .grant_cnt0(sat_cnt0), .grant_cnt1(sat_cnt1)
  );

  always #5 clk = ~clk;

  function automatic int pow2(input int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * 2;
    return p;
  endfunction

  // Shift semantics written as plain integer arithmetic on 0..15
  function automatic int m_shift(input int a, input int k, input int op);
    int p, sa, r;
    p = pow2(k);
    case (op)
      0, 1:    r = a / p + (a % p) * pow2(4 - k);
      2, 3:    r = (a * p) % 16 + a / pow2(4 - k);
      4:       r = a / p;
      5: begin
        sa = (a >= 8) ? a - 16 : a;
        r  = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        r  = (r + 16) % 16;
      end
      default: r = (a * p) % 16;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] model_ready();
    if (rst) return 2'b00;
    if (m_full != 0 && !res_ready) return 2'b00;
    if (req_valid == 2'b01) return 2'b01;
    if (req_valid == 2'b10) return 2'b10;
    if (req_valid == 2'b11) return (m_rr != 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic set_req(input int i, input int a, input int k, input int op);
    req_a[4*i +: 4]  = 4'(a);
    req_k[2*i +: 2]  = 2'(k);
    req_op[3*i +: 3] = 3'(op);
  endtask

  task automatic model_clear();
    m_full = 0; m_data = 0; m_id = 0; m_rr = 0;
    m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
    last_acc = 2'b00;
  endtask

  // One clock: predict the handshake from current inputs, then advance the model
  task automatic tick();
    logic [1:0] r;
    int w;
    r = model_ready();
    @(posedge clk);
    last_acc = r;
    if (!rst && r != 2'b00) begin
      w      = r[1] ? 1 : 0;
      m_data = m_shift(int'(req_a[4*w +: 4]), int'(req_k[2*w +: 2]), int'(req_op[3*w +: 3]));
      m_id   = w;
      m_full = 1;
      m_rr   = 1 - w;
      if (w == 0) begin
        m_c0 = (m_c0 < 255) ? m_c0 + 1 : 255;
        m_s0 = (m_s0 < 3) ? m_s0 + 1 : 3;
      end else begin
        m_c1 = (m_c1 < 255) ? m_c1 + 1 : 255;
        m_s1 = (m_s1 < 3) ? m_s1 + 1 : 3;
      end
    end else if (!rst && res_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b01; res_ready = 1'b1;
    req_a = 8'h00; req_k = 4'h0; req_op = 6'o00;
    set_req(0, 9, 1, 0);
    model_clear();
    #1;
    cmp_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL reset_ready actual=%b required=00", req_ready); end
    cmp_cnt++; if ({res_valid, res_data, res_id} !== 6'b0) begin err_cnt++; $display("FAIL reset_slot actual=%b%b%b required=0", res_valid, res_data, res_id); end
    cmp_cnt++; if ({grant_cnt0, grant_cnt1} !== 16'h0000) begin err_cnt++; $display("FAIL reset_cnt actual=%0d/%0d required=0/0", grant_cnt0, grant_cnt1); end
    @(posedge clk);
    #1;
    cmp_cnt++; if (res_valid !== 1'b0 || grant_cnt0 !== 8'd0) begin err_cnt++; $display("FAIL reset_edge_no_hs actual=%b/%0d required=0/0", res_valid, grant_cnt0); end
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single();
    set_req(0, 9, 1, 0);
    req_valid = 2'b01; res_ready = 1'b1;
    #1;
    cmp_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL single_ready actual=%b required=01", req_ready); end
    tick();
    req_valid = 2'b00;
    cmp_cnt++; if (res_valid !== 1'b1 || res_data !== 4'b1100 || res_id !== 1'b0) begin err_cnt++; $display("FAIL single_result actual=%b/%b/%b required=1/1100/0", res_valid, res_data, res_id); end
    cmp_cnt++; if (grant_cnt0 !== 8'd1) begin err_cnt++; $display("FAIL single_cnt0 actual=%0d required=1", grant_cnt0); end
    tick();
    cmp_cnt++; if (res_valid !== 1'b0 || res_data !== 4'b1100) begin err_cnt++; $display("FAIL single_drain actual=%b/%b required=0/1100", res_valid, res_data); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 11, 3, 4);
    set_req(1, 8, 2, 5);
    req_valid = 2'b11; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp_cnt++; if (req_ready !== ((i % 2) ? 2'b10 : 2'b01)) begin err_cnt++; $display("FAIL rr_ready[%0d] actual=%b required=%b", i, req_ready, (i % 2) ? 2'b10 : 2'b01); end
      tick();
      cmp_cnt++; if (res_valid !== 1'b1 || res_id !== 1'(i % 2) || res_data !== ((i % 2) ? 4'b1110 : 4'b0001)) begin err_cnt++; $display("FAIL rr_result[%0d] actual=%b/%b/%b required=1/%0d/%b", i, res_valid, res_id, res_data, i % 2, (i % 2) ? 4'b1110 : 4'b0001); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held_d;
    logic       held_id;
    res_ready = 1'b0;
    held_d = res_data; held_id = res_id;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL bp_ready[%0d] actual=%b required=00", i, req_ready); end
      tick();
      cmp_cnt++; if (res_valid !== 1'b1 || res_data !== held_d || res_id !== held_id || grant_cnt0 !== 8'(m_c0) || grant_cnt1 !== 8'(m_c1)) begin err_cnt++; $display("FAIL bp_hold[%0d] actual=%b/%b/%b/%0d/%0d required=1/%b/%b/%0d/%0d", i, res_valid, res_data, res_id, grant_cnt0, grant_cnt1, held_d, held_id, m_c0, m_c1); end
    end
    res_ready = 1'b1;
    #1;
    cmp_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL bp_release_ready actual=%b required=01", req_ready); end
    tick();
    cmp_cnt++; if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 4'b0001) begin err_cnt++; $display("FAIL bp_reload actual=%b/%b/%b required=1/0/0001", res_valid, res_id, res_data); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_req1_ops();
    int a_t[5], k_t[5], op_t[5], e_t[5];
    a_t[0] = 7; k_t[0] = 1; op_t[0] = 6; e_t[0] = 14;
    a_t[1] = 9; k_t[1] = 1; op_t[1] = 2; e_t[1] = 3;
    for (int j = 2; j < 5; j++) begin
      a_t[j] = $urandom_range(0, 15); k_t[j] = 0; op_t[j] = $urandom_range(0, 7); e_t[j] = a_t[j];
    end
    req_valid = 2'b10; res_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      set_req(1, a_t[j], k_t[j], op_t[j]);
      #1;
      cmp_cnt++; if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL req1_ready[%0d] actual=%b required=10", j, req_ready); end
      tick();
      cmp_cnt++; if (res_data !== 4'(e_t[j]) || res_id !== 1'b1) begin err_cnt++; $display("FAIL req1_result[%0d] a=%0d k=%0d op=%0d actual=%b/%b required=%b/1", j, a_t[j], k_t[j], op_t[j], res_data, res_id, 4'(e_t[j])); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    req_valid = 2'b01; res_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      set_req(0, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7));
      tick();
    end
    req_valid = 2'b00;
    cmp_cnt++; if (sat_cnt0 !== 2'd3 || sat_cnt1 !== 2'd0) begin err_cnt++; $display("FAIL sat_cnt actual=%0d/%0d required=3/0", sat_cnt0, sat_cnt1); end
    cmp_cnt++; if (grant_cnt0 !== 8'd5) begin err_cnt++; $display("FAIL wide_cnt0 actual=%0d required=5", grant_cnt0); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 5, 2, 1);
    req_valid = 2'b01; res_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    cmp_cnt++; if (res_valid !== 1'b1) begin err_cnt++; $display("FAIL mid_pending actual=%b required=1", res_valid); end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    cmp_cnt++; if (res_valid !== 1'b0 || grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0 || sat_cnt0 !== 2'd0) begin err_cnt++; $display("FAIL mid_async_clear actual=%b/%0d/%0d/%0d required=0/0/0/0", res_valid, grant_cnt0, grant_cnt1, sat_cnt0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(0, 3, 1, 6);
    set_req(1, 12, 1, 4);
    req_valid = 2'b11; res_ready = 1'b1;
    #1;
    cmp_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL mid_first_grant actual=%b required=01", req_ready); end
    tick();
    cmp_cnt++; if (res_id !== 1'b0 || res_data !== 4'b0110) begin err_cnt++; $display("FAIL mid_first_result actual=%b/%b required=0/0110", res_id, res_data); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !last_acc[i])) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7));
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      cmp_cnt++; if (req_ready !== model_ready()) begin err_cnt++; $display("FAIL rand_ready[%0d] actual=%b required=%b", c, req_ready, model_ready()); end
      tick();
      cmp_cnt++; if (res_valid !== 1'(m_full) || res_data !== 4'(m_data) || res_id !== 1'(m_id)) begin err_cnt++; $display("FAIL rand_slot[%0d] actual=%b/%b/%b required=%0d/%b/%0d", c, res_valid, res_data, res_id, m_full, 4'(m_data), m_id); end
      cmp_cnt++; if (grant_cnt0 !== 8'(m_c0) || grant_cnt1 !== 8'(m_c1) || sat_cnt0 !== 2'(m_s0) || sat_cnt1 !== 2'(m_s1)) begin err_cnt++; $display("FAIL rand_cnt[%0d] actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d", c, grant_cnt0, grant_cnt1, sat_cnt0, sat_cnt1, m_c0, m_c1, m_s0, m_s1); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_req1_ops();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
